mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, multi-cycle MUL/DIV sequencing and hazard stall.
// Optional MADD/MSUB (ops 6/7) are enabled by defining MDU_MADD_EN; otherwise those ops are no-ops.
module mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_t;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    op_t         op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Result datapath, evaluated from the latched operands and the current HI/LO.
    logic [63:0]        prod_u;
    logic signed [63:0] prod_s;
    logic signed [31:0] sa, sb;
    logic [63:0]        acc;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;

    always_comb begin
        sa     = $signed(a_q);
        sb     = $signed(b_q);
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        acc    = {hi_q, lo_q};
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        unique case (op_q)
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                    res_wr = 1'b1;
                end
            end
            OP_DIV: begin
                // The one signed overflow case is pinned explicitly rather than left to the divider.
                if (b_q == 32'd0) begin
                    res_wr = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'h0000_0000;
                    res_wr = 1'b1;
                end else begin
                    res_lo = 32'(sa / sb);
                    res_hi = 32'(sa % sb);
                    res_wr = 1'b1;
                end
            end
            OP_MADD: begin
                {res_hi, res_lo} = acc + prod_s;
                res_wr = 1'b1;
            end
            OP_MSUB: begin
                {res_hi, res_lo} = acc - prod_s;
                res_wr = 1'b1;
            end
            default: res_wr = 1'b0;
        endcase
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    unique case (op_t'(op))
                        OP_MULTU, OP_MULT: begin
                            state_d = S_MUL;
                            cnt_d   = MUL_LOAD;
                            op_d    = op_t'(op);
                            a_d     = inputA;
                            b_d     = inputB;
                        end
                        OP_DIVU, OP_DIV: begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                            op_d    = op_t'(op);
                            a_d     = inputA;
                            b_d     = inputB;
                        end
                        OP_MTHI: hi_d = inputA;
                        OP_MTLO: lo_d = inputA;
                        OP_MADD, OP_MSUB: begin
                            if (MADD_EN) begin
                                state_d = S_MUL;
                                cnt_d   = MUL_LOAD;
                                op_d    = op_t'(op);
                                a_d     = inputA;
                                b_d     = inputB;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            op_q  <= OP_MULTU;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign busy      = (state != S_IDLE);
    assign stall_req = start | busy;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule
